// File: rtl/ntt_ctrl.sv
// Sequencer for the in-place Kyber NTT/INTT over one 256-coefficient polynomial.
// Issues one butterfly per cycle for 7 layers and drains the datapath between layers.
module ntt_ctrl #(
  parameter int unsigned BF_LAT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       inv,
  output logic       busy,
  output logic       done,
  output logic       mode,
  output logic [2:0] layer,
  output logic       rd_en,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [6:0] zeta_idx,
  output logic       bf_valid,
  output logic       wr_en,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b
);

  localparam int unsigned DL = 1 + BF_LAT;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t      state, state_next;
  logic [6:0]  b_cnt, b_next;
  logic [2:0]  layer_cnt, layer_next;
  logic [15:0] drain_cnt, drain_next;
  logic        mode_next;

  logic [2:0]  lg;
  logic [3:0]  lg1;
  logic [7:0]  bw, span, grp, j_addr, zeta_fwd, zeta_inv;
  logic [6:0]  zeta_next;

  logic        dv [DL];
  logic [7:0]  da [DL];
  logic [7:0]  db [DL];

  always_comb begin
    state_next = state;
    b_next     = b_cnt;
    layer_next = layer_cnt;
    drain_next = drain_cnt;
    mode_next  = mode;
    case (state)
      IDLE: begin
        if (start) begin
          mode_next  = inv;
          layer_next = '0;
          b_next     = '0;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        b_next = b_cnt + 7'd1;
        if (b_cnt == 7'd127) begin
          drain_next = '0;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // 1+BF_LAT idle cycles so the last write lands before the next layer's first read
        if (drain_cnt == 16'(BF_LAT)) begin
          if (layer_cnt == 3'd6) begin
            state_next = FIN;
          end else begin
            layer_next = layer_cnt + 3'd1;
            b_next     = '0;
            state_next = ISSUE;
          end
        end else begin
          drain_next = drain_cnt + 16'd1;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    lg        = mode ? (layer_cnt + 3'd1) : (3'd7 - layer_cnt);
    lg1       = {1'b0, lg} + 4'd1;
    bw        = {1'b0, b_cnt};
    span      = 8'd1 << lg;
    grp       = bw >> lg;
    j_addr    = (grp << lg1) | (bw & (span - 8'd1));
    zeta_fwd  = (8'd1 << layer_cnt) + grp;
    zeta_inv  = (8'd128 >> layer_cnt) - 8'd1 - grp;
    zeta_next = mode ? zeta_inv[6:0] : zeta_fwd[6:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      b_cnt     <= '0;
      layer_cnt <= '0;
      drain_cnt <= '0;
      mode      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      layer     <= '0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      zeta_idx  <= '0;
    end else begin
      state     <= state_next;
      b_cnt     <= b_next;
      layer_cnt <= layer_next;
      drain_cnt <= drain_next;
      mode      <= mode_next;
      busy      <= (state == ISSUE) || (state == DRAIN);
      done      <= (state == FIN);
      rd_en     <= (state == ISSUE);
      if (state == ISSUE) begin
        layer     <= layer_cnt;
        rd_addr_a <= j_addr;
        rd_addr_b <= j_addr + span;
        zeta_idx  <= zeta_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DL; i++) begin
        dv[i] <= 1'b0;
        da[i] <= '0;
        db[i] <= '0;
      end
    end else begin
      dv[0] <= rd_en;
      da[0] <= rd_addr_a;
      db[0] <= rd_addr_b;
      for (int unsigned i = 1; i < DL; i++) begin
        dv[i] <= dv[i-1];
        da[i] <= da[i-1];
        db[i] <= db[i-1];
      end
    end
  end

  assign bf_valid  = dv[0];
  assign wr_en     = dv[DL-1];
  assign wr_addr_a = da[DL-1];
  assign wr_addr_b = db[DL-1];

endmodule
